gb_vga_pixel_out: RTL

GB_VGA_PIXEL_OUT -- requirements
Module: gb_vga_pixel_out

---
 rtl/gb_vga_pkg.sv | 52 +++++
 rtl/gb_vga_delay.sv | 27 ++
 rtl/gb_vga_pixel_out.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gb_vga_pkg.sv
// Shared types, constants and palette helpers for the Game Boy to VGA pixel path.
package gb_vga_pkg;

  localparam int GB_W = 160;
  localparam int GB_H = 144;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    PAL_DMG  = 1'b0,
    PAL_GREY = 1'b1
  } pal_t;

  // Per-pixel information that must travel alongside the framebuffer read
  typedef struct packed {
    logic hs;
    logic vs;
    logic en;
    logic border;
    logic dark;
    pal_t pal;
  } sideband_t;

  localparam sideband_t SB_IDLE = '{hs: 1'b1, vs: 1'b1, en: 1'b0, border: 1'b0,
                                    dark: 1'b0, pal: PAL_DMG};

  localparam logic [23:0] DMG_PAL  [4] = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};
  localparam logic [23:0] GREY_PAL [4] = '{24'hFFFFFF, 24'hAAAAAA, 24'h555555, 24'h000000};

  function automatic rgb_t pal_lookup(input pal_t pal, input logic [1:0] shade);
    rgb_t c;
    case (pal)
      PAL_DMG:  c = rgb_t'(DMG_PAL[shade]);
      PAL_GREY: c = rgb_t'(GREY_PAL[shade]);
      default:  c = rgb_t'(DMG_PAL[shade]);
    endcase
    return c;
  endfunction

  function automatic rgb_t halve(input rgb_t c);
    rgb_t h;
    h.r = {1'b0, c.r[7:1]};
    h.g = {1'b0, c.g[7:1]};
    h.b = {1'b0, c.b[7:1]};
    return h;
  endfunction

endpackage

// File: rtl/gb_vga_delay.sv
// N-deep, W-wide shift register with a synchronous reset value.
module gb_vga_delay #(
  parameter int N = 4,
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_r [N];

  // Shift chain; reset loads every stage with the idle value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stage_r[i] <= RST_VAL;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < N; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[N-1];

endmodule

// File: rtl/gb_vga_pixel_out.sv
// Framebuffer fetch and colour output stage; every output lags its inputs by FB_LAT+2 clocks.
module gb_vga_pixel_out
  import gb_vga_pkg::*;
#(
  parameter int          FB_LAT     = 2,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        enable_in,
  input  logic        gb_en,
  input  logic [7:0]  gb_x,
  input  logic [7:0]  gb_y,
  input  logic        gb_grid,
  input  logic        grid_on,
  input  logic        pal_sel,
  output logic        fb_rd,
  output logic [14:0] fb_addr,
  input  logic [1:0]  fb_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n
);

  logic      vs_prev_r;
  pal_t      pal_r;
  pal_t      pal_cur_s;
  logic      in_range_s;
  logic      rd_ok_s;
  logic [14:0] addr_s;
  sideband_t sb_in_s;
  sideband_t sb_out_s;
  rgb_t      rgb_s;
  logic      blank_n_s;

  // Palette switch on the vs falling edge, taking pal_sel from that same clock
  always_comb begin
    pal_cur_s = pal_r;
    if (vs_prev_r && !vs_in) begin
      pal_cur_s = pal_t'(pal_sel);
    end else begin
      pal_cur_s = pal_r;
    end
  end

  // Active palette and vs history
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_r <= 1'b1;
      pal_r     <= PAL_DMG;
    end else begin
      vs_prev_r <= vs_in;
      pal_r     <= pal_cur_s;
    end
  end

  assign in_range_s = (gb_x < 8'(GB_W)) && (gb_y < 8'(GB_H));
  assign rd_ok_s    = gb_en && in_range_s;
  // y*160 as y*128 + y*32
  assign addr_s     = ({7'd0, gb_y} << 7) + ({7'd0, gb_y} << 5) + {7'd0, gb_x};

  // Stage 1: address register holds its value when no read is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_rd   <= 1'b0;
      fb_addr <= 15'd0;
    end else begin
      fb_rd <= rd_ok_s;
      if (rd_ok_s) fb_addr <= addr_s;
    end
  end

  always_comb begin
    sb_in_s        = SB_IDLE;
    sb_in_s.hs     = hs_in;
    sb_in_s.vs     = vs_in;
    sb_in_s.en     = enable_in;
    sb_in_s.border = !rd_ok_s;
    sb_in_s.dark   = grid_on && gb_grid;
    sb_in_s.pal    = pal_cur_s;
  end

  gb_vga_delay #(
    .N       (FB_LAT + 1),
    .W       ($bits(sideband_t)),
    .RST_VAL (SB_IDLE)
  ) u_sb_delay (
    .clk (clk),
    .rst (rst),
    .d   (sb_in_s),
    .q   (sb_out_s)
  );

  // Final colour select, aligned with the returning fb_data
  always_comb begin
    rgb_s     = rgb_t'(24'h000000);
    blank_n_s = 1'b0;
    if (!sb_out_s.en) begin
      rgb_s     = rgb_t'(24'h000000);
      blank_n_s = 1'b0;
    end else if (sb_out_s.border) begin
      rgb_s     = rgb_t'(BORDER_RGB);
      blank_n_s = 1'b1;
    end else begin
      if (sb_out_s.dark) begin
        rgb_s = halve(pal_lookup(sb_out_s.pal, fb_data));
      end else begin
        rgb_s = pal_lookup(sb_out_s.pal, fb_data);
      end
      blank_n_s = 1'b1;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= 8'd0;
      vga_g       <= 8'd0;
      vga_b       <= 8'd0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= rgb_s.r;
      vga_g       <= rgb_s.g;
      vga_b       <= rgb_s.b;
      vga_hs      <= sb_out_s.hs;
      vga_vs      <= sb_out_s.vs;
      vga_blank_n <= blank_n_s;
    end
  end

endmodule
